video_stream_src: RTL

//  Source end of the 8-bit grey video stream (data/de/hs/vs) consumed by the edge-detection chain.

---
 rtl/video_timing_pkg.sv | 27 ++
 rtl/vid_pattern_gen.sv | 34 +++
 rtl/video_stream_src.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/video_timing_pkg.sv
// Shared raster defaults (VGA 640x480) and the type codes used by the video stream source.
`timescale 1ns/1ps
package video_timing_pkg;

   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;
   localparam int DEF_CNT_W    = 11;

   typedef enum logic [1:0] {
      PAT_EXT    = 2'd0,
      PAT_RAMP   = 2'd1,
      PAT_CHECK  = 2'd2,
      PAT_BORDER = 2'd3
   } patSel_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } runState_t;

endpackage

// File: rtl/vid_pattern_gen.sv
// Combinational test-pattern pixel for a raster position: ramp, 32x32 checker or 1-px white border.
`timescale 1ns/1ps
module vid_pattern_gen
   import video_timing_pkg::*;
#(
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int CNT_W    = DEF_CNT_W
) (
   input  logic [CNT_W-1:0] i_x,
   input  logic [CNT_W-1:0] i_y,
   input  patSel_t          i_pat,
   output logic [7:0]       o_pix
);

   localparam logic [CNT_W-1:0] X_LAST = CNT_W'(H_ACTIVE - 1);
   localparam logic [CNT_W-1:0] Y_LAST = CNT_W'(V_ACTIVE - 1);

   logic w_onBorder;

   assign w_onBorder = (i_x == '0) || (i_x == X_LAST) || (i_y == '0) || (i_y == Y_LAST);

   // External mode has no pattern of its own; the top substitutes the upstream pixel.
   always_comb begin
      o_pix = 8'h00;
      case (i_pat)
         PAT_RAMP:   o_pix = i_x[7:0];
         PAT_CHECK:  o_pix = (i_x[5] ^ i_y[5]) ? 8'hFF : 8'h00;
         PAT_BORDER: o_pix = w_onBorder ? 8'hFF : 8'h00;
         default:    o_pix = 8'h00;
      endcase
   end

endmodule

// File: rtl/video_stream_src.sv
// Raster timing generator and registered 8-bit grey video source feeding the edge-detection chain.
`timescale 1ns/1ps
module video_stream_src
   import video_timing_pkg::*;
#(
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FP     = DEF_H_FP,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BP     = DEF_H_BP,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FP     = DEF_V_FP,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BP     = DEF_V_BP,
   parameter int CNT_W    = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst_s,
   input  logic             en,
   input  logic [1:0]       pat_sel,
   input  logic [7:0]       pix_in,
   input  logic             pix_valid,
   output logic             pix_ready,
   output logic [7:0]       vid_data,
   output logic             vid_de,
   output logic             vid_hs,
   output logic             vid_vs,
   output logic [CNT_W-1:0] vid_x,
   output logic [CNT_W-1:0] vid_y,
   output logic             frame_start,
   output logic             underflow
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] H_ACT_END = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] V_ACT_END = CNT_W'(V_ACTIVE);
   localparam logic [CNT_W-1:0] HS_BEG    = CNT_W'(H_ACTIVE + H_FP);
   localparam logic [CNT_W-1:0] HS_END    = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CNT_W-1:0] VS_BEG    = CNT_W'(V_ACTIVE + V_FP);
   localparam logic [CNT_W-1:0] VS_END    = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

   runState_t        r_state;
   runState_t        w_stateNext;
   logic [CNT_W-1:0] r_hCnt;
   logic [CNT_W-1:0] r_vCnt;
   patSel_t          r_patLat;

   logic             w_run;
   logic             w_lineEnd;
   logic             w_frameEnd;
   logic             w_frameEntry;
   logic             w_act;
   logic             w_ext;
   logic             w_pixReady;
   logic             w_miss;
   logic             w_first;
   logic             w_hsN;
   logic             w_vsN;
   logic [7:0]       w_patPix;
   logic [7:0]       w_pixNext;

   logic [7:0]       r_data;
   logic             r_de;
   logic             r_hs;
   logic             r_vs;
   logic [CNT_W-1:0] r_x;
   logic [CNT_W-1:0] r_y;
   logic             r_fs;
   logic             r_uf;

   assign w_run        = (r_state == ST_RUN);
   assign w_lineEnd    = (r_hCnt == H_LAST);
   assign w_frameEnd   = w_lineEnd && (r_vCnt == V_LAST);
   assign w_frameEntry = en && (!w_run || w_frameEnd);
   assign w_act        = w_run && (r_hCnt < H_ACT_END) && (r_vCnt < V_ACT_END);
   assign w_ext        = (r_patLat == PAT_EXT);
   assign w_pixReady   = w_act && w_ext;
   assign w_miss       = w_pixReady && !pix_valid;
   assign w_first      = w_act && (r_hCnt == '0) && (r_vCnt == '0);
   assign w_hsN        = !((r_hCnt >= HS_BEG) && (r_hCnt < HS_END));
   assign w_vsN        = !((r_vCnt >= VS_BEG) && (r_vCnt < VS_END));

   always_ff @(posedge clk or negedge rst_s) begin
      if (!rst_s) r_state <= ST_IDLE;
      else        r_state <= w_stateNext;
   end

   // Stopping is only honoured on the last pixel of a frame, so a frame is never cut short.
   always_comb begin
      w_stateNext = r_state;
      case (r_state)
         ST_IDLE: if (en) w_stateNext = ST_RUN;
         ST_RUN:  if (w_frameEnd && !en) w_stateNext = ST_IDLE;
         default: w_stateNext = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_s) begin
      if (!rst_s) begin
         r_hCnt <= '0;
         r_vCnt <= '0;
      end else if (w_run) begin
         if (w_lineEnd) begin
            r_hCnt <= '0;
            r_vCnt <= (r_vCnt == V_LAST) ? '0 : r_vCnt + 1'b1;
         end else begin
            r_hCnt <= r_hCnt + 1'b1;
         end
      end
   end

   // The mode is captured as the counters enter (0,0), so the whole frame sees one stable mode
   // and pix_ready stays a function of registered state only.
   always_ff @(posedge clk or negedge rst_s) begin
      if (!rst_s)            r_patLat <= PAT_EXT;
      else if (w_frameEntry) r_patLat <= patSel_t'(pat_sel);
   end

   vid_pattern_gen #(
      .H_ACTIVE (H_ACTIVE),
      .V_ACTIVE (V_ACTIVE),
      .CNT_W    (CNT_W)
   ) u_patGen (
      .i_x   (r_hCnt),
      .i_y   (r_vCnt),
      .i_pat (r_patLat),
      .o_pix (w_patPix)
   );

   always_comb begin
      w_pixNext = 8'h00;
      if (w_act) begin
         if (!w_ext)         w_pixNext = w_patPix;
         else if (pix_valid) w_pixNext = pix_in;
      end
   end

   // A missing pixel in the first position of a frame must still be reported, so set beats clear.
   always_ff @(posedge clk or negedge rst_s) begin
      if (!rst_s) begin
         r_data <= 8'h00;
         r_de   <= 1'b0;
         r_hs   <= 1'b1;
         r_vs   <= 1'b1;
         r_x    <= '0;
         r_y    <= '0;
         r_fs   <= 1'b0;
         r_uf   <= 1'b0;
      end else begin
         r_data <= w_pixNext;
         r_de   <= w_act;
         r_hs   <= w_hsN;
         r_vs   <= w_vsN;
         r_fs   <= w_first;
         if (w_act) begin
            r_x <= r_hCnt;
            r_y <= r_vCnt;
         end
         if (w_miss)       r_uf <= 1'b1;
         else if (w_first) r_uf <= 1'b0;
      end
   end

   assign pix_ready   = w_pixReady;
   assign vid_data    = r_data;
   assign vid_de      = r_de;
   assign vid_hs      = r_hs;
   assign vid_vs      = r_vs;
   assign vid_x       = r_x;
   assign vid_y       = r_y;
   assign frame_start = r_fs;
   assign underflow   = r_uf;

endmodule
